// File: rtl/fns_collect_pkg.sv
// Shared types and constants for the function-evaluation result collector.
// Optional MISR compression is enabled by defining VL_SYSTEST_MISR_EN.
package fns_collect_pkg;

    localparam int SAMPLE_W      = 40;
    localparam int DEFAULT_DEPTH = 4;

    // Feedback taps for x^40+x^38+x^21+x^19+1 (bits 39, 37, 20, 18)
    localparam logic [SAMPLE_W-1:0] MISR_TAPS = 40'h00_0014_0000
                                              | 40'hA0_0000_0000;

    typedef struct packed {
        logic [7:0] r5;
        logic [7:0] r4;
        logic [7:0] r3;
        logic [7:0] r2;
        logic [7:0] r1;
    } fns_sample_t;

    // One MISR step: shift in the parity of the tapped bits, then fold the sample
    function automatic logic [SAMPLE_W-1:0] misr_next(
        input logic [SAMPLE_W-1:0] sig,
        input logic [SAMPLE_W-1:0] sample
    );
        logic fb;
        fb = ^(sig & MISR_TAPS);
        return {sig[SAMPLE_W-2:0], fb} ^ sample;
    endfunction

endpackage

// File: rtl/fns_collect_fifo.sv
// Generic valid/ready FIFO with synchronous clear.
// Registered output only; no input-to-output bypass and no pass-through when full.
module fns_collect_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full && !clr;
    assign pop       = out_ready && !empty && !clr;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    // Storage array; stale entries are masked by the empty flag
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; clear wins over any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fns_result_collector.sv
// Captures the five DUT results as one sample, buffers, counts and signs them.
// Define VL_SYSTEST_MISR_EN to build the 40-bit MISR signature register.
module fns_result_collector
    import fns_collect_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          res1,
    input  logic [7:0]          res2,
    input  logic [7:0]          res3,
    input  logic [7:0]          res4,
    input  logic [7:0]          res5,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic                cnt_sat,
    output logic [SAMPLE_W-1:0] signature
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fns_sample_t sample;
    logic        accept;

    assign sample.r1 = res1;
    assign sample.r2 = res2;
    assign sample.r3 = res3;
    assign sample.r4 = res4;
    assign sample.r5 = res5;

    assign accept = in_valid && in_ready && !clr;

    fns_collect_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Saturating accepted-sample counter with sticky saturation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (clr) begin
            sample_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (accept && sample_cnt != CNT_MAX) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == CNT_MAX - 1'b1) begin
                cnt_sat <= 1'b1;
            end
        end
    end

`ifdef VL_SYSTEST_MISR_EN
    logic [SAMPLE_W-1:0] sig_q;

    // MISR compresses each accepted sample; holds on idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (accept) begin
            sig_q <= misr_next(sig_q, sample);
        end
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule
